// File: rtl/psg_pkg.sv
// Shared PSG definitions: envelope shape bit positions, level widths for the
// AY-3-891x and YM2149 variants, and the named envelope shape encodings.
package psg_pkg;

    localparam int unsigned SHAPE_W = 4;

    // Bit positions inside the 4-bit envelope shape register
    localparam int unsigned SHAPE_CONTINUE  = 3;
    localparam int unsigned SHAPE_ATTACK    = 2;
    localparam int unsigned SHAPE_ALTERNATE = 1;
    localparam int unsigned SHAPE_HOLD      = 0;

    // Envelope level widths
    localparam int unsigned STEP_BITS_AY = 4;
    localparam int unsigned STEP_BITS_YM = 5;

    // Latched shape register; 'continue' is a keyword, hence 'cont'
    typedef struct packed {
        logic cont;
        logic attack;
        logic alternate;
        logic hold;
    } shape_t;

    // Named shape encodings (shapes 1-7 all behave like 0 or 4)
    localparam logic [SHAPE_W-1:0] SHAPE_FALL_HOLD_LOW  = 4'd0;
    localparam logic [SHAPE_W-1:0] SHAPE_SAW_DOWN       = 4'd8;
    localparam logic [SHAPE_W-1:0] SHAPE_FALL_ONCE      = 4'd9;
    localparam logic [SHAPE_W-1:0] SHAPE_TRI_DOWN       = 4'd10;
    localparam logic [SHAPE_W-1:0] SHAPE_FALL_HOLD_HIGH = 4'd11;
    localparam logic [SHAPE_W-1:0] SHAPE_SAW_UP         = 4'd12;
    localparam logic [SHAPE_W-1:0] SHAPE_RISE_HOLD_HIGH = 4'd13;
    localparam logic [SHAPE_W-1:0] SHAPE_TRI_UP         = 4'd14;
    localparam logic [SHAPE_W-1:0] SHAPE_RISE_HOLD_LOW  = 4'd15;

endpackage

// File: rtl/psg_period_counter.sv
// Tick divider shared by the PSG tone, noise and envelope generators.
// Counts tick strobes and flags a step every max(period,1) ticks.
//   clk, reset : clock and synchronous active-high reset
//   tick       : clock-enable strobe advancing the counter
//   clear      : restarts the count; suppresses a coincident step
//   period     : divide ratio, read live (0 behaves as 1)
//   step       : combinational, high on the tick that completes a period
module psg_period_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             clear,
    input  logic [WIDTH-1:0] period,
    output logic             step
);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] last;
    logic             at_last;

    // Last count value of a period; >= also covers a period shrunk below count
    always_comb begin
        last    = (period == '0) ? '0 : period - WIDTH'(1);
        at_last = (count >= last);
    end

    assign step = tick && !clear && at_last;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (tick) begin
            count <= at_last ? '0 : count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/psg_envelope_generator.sv
// PSG envelope generator: steps a level ramp at the divided tick rate and
// shapes it (attack/decay, sawtooth, triangle, hold) from the latched shape.
//   clk, reset : clock and synchronous active-high reset
//   tick       : clock-enable strobe for the period divider
//   period     : envelope step period in ticks, read live
//   shape      : {continue, attack, alternate, hold}, latched on restart
//   restart    : one-cycle pulse on a shape register write
//   out        : registered envelope level
//   holding    : registered, high while frozen at the final level
module psg_envelope_generator
    import psg_pkg::*;
#(
    parameter int unsigned PERIOD_BITS = 16,
    parameter int unsigned STEP_BITS   = STEP_BITS_AY
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   tick,
    input  logic [PERIOD_BITS-1:0] period,
    input  logic [SHAPE_W-1:0]     shape,
    input  logic                   restart,
    output logic [STEP_BITS-1:0]   out,
    output logic                   holding
);

    localparam logic [STEP_BITS-1:0] LEVEL_MAX = {STEP_BITS{1'b1}};

    logic                 step;
    shape_t               shape_q, shape_n;
    logic [STEP_BITS-1:0] position, position_n;
    logic [STEP_BITS-1:0] hold_level, hold_level_n;
    logic [STEP_BITS-1:0] out_n;
    logic                 dir_up, dir_up_n;
    logic                 holding_n;

    psg_period_counter #(
        .WIDTH (PERIOD_BITS)
    ) u_period_counter (
        .clk    (clk),
        .reset  (reset),
        .tick   (tick),
        .clear  (restart),
        .period (period),
        .step   (step)
    );

    // Level sequencer next state; out is derived from the next state so it
    // changes on the same edge as the step or restart
    always_comb begin
        shape_n      = shape_q;
        position_n   = position;
        dir_up_n     = dir_up;
        holding_n    = holding;
        hold_level_n = hold_level;

        if (restart) begin
            shape_n    = shape_t'(shape);
            position_n = '0;
            dir_up_n   = shape[SHAPE_ATTACK];
            holding_n  = 1'b0;
        end else if (step && !holding) begin
            if (position != LEVEL_MAX) begin
                position_n = position + STEP_BITS'(1);
            end else if (!shape_q.cont) begin
                holding_n    = 1'b1;
                hold_level_n = '0;
            end else if (shape_q.hold) begin
                holding_n    = 1'b1;
                hold_level_n = (dir_up ^ shape_q.alternate) ? LEVEL_MAX : '0;
            end else begin
                // Wrapping position with a direction flip repeats the endpoint
                position_n = '0;
                if (shape_q.alternate) begin
                    dir_up_n = ~dir_up;
                end
            end
        end

        if (holding_n) begin
            out_n = hold_level_n;
        end else if (dir_up_n) begin
            out_n = position_n;
        end else begin
            out_n = LEVEL_MAX - position_n;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shape_q    <= '0;
            position   <= '0;
            dir_up     <= 1'b0;
            holding    <= 1'b1;
            hold_level <= '0;
            out        <= '0;
        end else begin
            shape_q    <= shape_n;
            position   <= position_n;
            dir_up     <= dir_up_n;
            holding    <= holding_n;
            hold_level <= hold_level_n;
            out        <= out_n;
        end
    end

endmodule

// File: tb/tb_psg_envelope_generator.sv
// Self-checking bench for psg_envelope_generator: table-driven shape ramps on
// an AY-width instance plus hand-written reset and YM-width sequences.
module tb_psg_envelope_generator;
    import psg_pkg::*;

    localparam int unsigned PB = 16;

    typedef struct {
        string       tag;
        logic        rst;
        logic        rs;
        logic        tk;
        logic [3:0]  shp;
        logic [PB-1:0] per;
        logic [4:0]  exp_out;
        logic        exp_hold;
    } vec_t;

    vec_t vecs[$];

    logic          clk = 1'b0;
    logic          reset;
    logic          tick;
    logic          restart;
    logic [3:0]    shape;
    logic [PB-1:0] period;
    logic [3:0]    out_ay;
    logic          hold_ay;
    logic [4:0]    out_ym;
    logic          hold_ym;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    psg_envelope_generator #(.PERIOD_BITS(PB), .STEP_BITS(STEP_BITS_AY)) dut_ay (
        .clk(clk), .reset(reset), .tick(tick), .period(period),
        .shape(shape), .restart(restart), .out(out_ay), .holding(hold_ay)
    );

    psg_envelope_generator #(.PERIOD_BITS(PB), .STEP_BITS(STEP_BITS_YM)) dut_ym (
        .clk(clk), .reset(reset), .tick(tick), .period(period),
        .shape(shape), .restart(restart), .out(out_ym), .holding(hold_ym)
    );

    function automatic void add(input string tag, input logic rst, input logic rs,
                                input logic tk, input logic [3:0] shp,
                                input int per, input int eo, input logic eh);
        vec_t v;
        v.tag = tag; v.rst = rst; v.rs = rs; v.tk = tk; v.shp = shp;
        v.per = PB'(per); v.exp_out = 5'(eo); v.exp_hold = eh;
        vecs.push_back(v);
    endfunction

    task automatic drive(input logic rst, input logic rs, input logic tk,
                         input logic [3:0] shp, input logic [PB-1:0] per);
        @(negedge clk);
        reset = rst; restart = rs; tick = tk; shape = shp; period = per;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int idx, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s step %0d: got %0d, expected %0d", tag, idx, act, exp);
        end
    endtask

    initial begin
        reset = 1'b1; restart = 1'b0; tick = 1'b0; shape = 4'd0; period = '0;

        // Reset with tick toggling, restart blocked by reset, then release
        add("reset", 1, 0, 1, 0, 1, 0, 1);
        add("reset", 1, 0, 0, 0, 1, 0, 1);
        add("reset_vs_restart", 1, 1, 1, 13, 1, 0, 1);
        add("post_reset", 0, 0, 1, 0, 1, 0, 1);
        add("post_reset", 0, 0, 0, 0, 1, 0, 1);
        add("post_reset", 0, 0, 1, 0, 1, 0, 1);

        // Attack and hold (13), period 1, restart coincident with tick
        add("s13_restart", 0, 1, 1, 13, 1, 0, 0);
        for (int l = 1; l <= 15; l++) add("s13_ramp", 0, 0, 1, 13, 1, l, 0);
        add("s13_hold", 0, 0, 1, 13, 1, 15, 1);
        add("s13_hold", 0, 0, 1, 13, 1, 15, 1);

        // Sawtooth down (8), period 2: each level twice, then wraps to 15
        add("s8_restart", 0, 1, 0, 8, 2, 15, 0);
        add("s8_saw", 0, 0, 1, 8, 2, 15, 0);
        for (int l = 14; l >= 0; l--) begin
            add("s8_saw", 0, 0, 1, 8, 2, l, 0);
            add("s8_saw", 0, 0, 1, 8, 2, l, 0);
        end
        add("s8_wrap", 0, 0, 1, 8, 2, 15, 0);
        add("s8_wrap", 0, 0, 1, 8, 2, 15, 0);
        add("s8_wrap", 0, 0, 1, 8, 2, 14, 0);

        // Triangle (14), period 0 acts as 1, endpoints repeated
        add("s14_restart", 0, 1, 0, 14, 0, 0, 0);
        for (int l = 1; l <= 15; l++) add("s14_up", 0, 0, 1, 14, 0, l, 0);
        for (int l = 15; l >= 0; l--) add("s14_down", 0, 0, 1, 14, 0, l, 0);
        for (int l = 0; l <= 15; l++) add("s14_up2", 0, 0, 1, 14, 0, l, 0);

        // Decay then hold low (0)
        add("s0_restart", 0, 1, 0, 0, 1, 15, 0);
        for (int l = 14; l >= 0; l--) add("s0_ramp", 0, 0, 1, 0, 1, l, 0);
        add("s0_hold", 0, 0, 1, 0, 1, 0, 1);
        add("s0_hold", 0, 0, 1, 0, 1, 0, 1);

        // Decay then hold high (11)
        add("s11_restart", 0, 1, 0, 11, 1, 15, 0);
        for (int l = 14; l >= 0; l--) add("s11_ramp", 0, 0, 1, 11, 1, l, 0);
        add("s11_hold", 0, 0, 1, 11, 1, 15, 1);
        add("s11_hold", 0, 0, 1, 11, 1, 15, 1);

        // Attack then hold low (15)
        add("s15_restart", 0, 1, 0, 15, 1, 0, 0);
        for (int l = 1; l <= 15; l++) add("s15_ramp", 0, 0, 1, 15, 1, l, 0);
        add("s15_hold", 0, 0, 1, 15, 1, 0, 1);
        add("s15_hold", 0, 0, 1, 15, 1, 0, 1);

        // Restart coincident with a stepping tick, period 3: no step taken
        add("rs_tick", 0, 1, 0, 13, 3, 0, 0);
        add("rs_tick", 0, 0, 1, 13, 3, 0, 0);
        add("rs_tick", 0, 0, 1, 13, 3, 0, 0);
        add("rs_tick", 0, 0, 1, 13, 3, 1, 0);
        add("rs_tick", 0, 0, 1, 13, 3, 1, 0);
        add("rs_tick", 0, 0, 1, 13, 3, 1, 0);
        add("rs_tick_coincident", 0, 1, 1, 13, 3, 0, 0);
        add("rs_tick_after", 0, 0, 1, 13, 3, 0, 0);
        add("rs_tick_after", 0, 0, 1, 13, 3, 0, 0);
        add("rs_tick_after", 0, 0, 1, 13, 3, 1, 0);

        // Period shrunk below counter, and no-tick cycles hold the counter
        add("shrink", 0, 1, 0, 13, 5, 0, 0);
        add("shrink", 0, 0, 1, 13, 5, 0, 0);
        add("shrink", 0, 0, 1, 13, 5, 0, 0);
        add("shrink", 0, 0, 1, 13, 5, 0, 0);
        add("shrink_step", 0, 0, 1, 13, 2, 1, 0);
        add("no_tick", 0, 0, 0, 13, 2, 1, 0);
        add("no_tick", 0, 0, 0, 13, 2, 1, 0);
        add("no_tick", 0, 0, 1, 13, 2, 1, 0);
        add("no_tick", 0, 0, 1, 13, 2, 2, 0);

        // Shape input changes without restart are ignored (latched 13 holds at 15)
        add("latch_restart", 0, 1, 0, 13, 1, 0, 0);
        for (int l = 1; l <= 15; l++) add("latch_ramp", 0, 0, 1, 8, 1, l, 0);
        add("latch_hold", 0, 0, 1, 0, 1, 15, 1);
        add("latch_hold", 0, 0, 1, 10, 1, 15, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].rs, vecs[i].tk, vecs[i].shp, vecs[i].per);
            check({vecs[i].tag, "_out"}, i, int'(out_ay), int'(vecs[i].exp_out));
            check({vecs[i].tag, "_holding"}, i, int'(hold_ay), int'(vecs[i].exp_hold));
        end

        // YM width: shape 13 ramps 0..31, then holds 31
        drive(1'b0, 1'b1, 1'b0, 4'd13, PB'(1));
        check("ym_restart_out", 0, int'(out_ym), 0);
        check("ym_restart_holding", 0, int'(hold_ym), 0);
        for (int l = 1; l <= 31; l++) begin
            drive(1'b0, 1'b0, 1'b1, 4'd13, PB'(1));
            check("ym_ramp_out", l, int'(out_ym), l);
            check("ym_ramp_holding", l, int'(hold_ym), 0);
        end
        for (int k = 0; k < 2; k++) begin
            drive(1'b0, 1'b0, 1'b1, 4'd13, PB'(1));
            check("ym_hold_out", k, int'(out_ym), 31);
            check("ym_hold_holding", k, int'(hold_ym), 1);
        end

        // Reset mid-ramp beats a coincident restart and tick
        drive(1'b0, 1'b1, 1'b0, 4'd14, PB'(0));
        for (int l = 1; l <= 3; l++) begin
            drive(1'b0, 1'b0, 1'b1, 4'd14, PB'(0));
            check("midramp_out", l, int'(out_ay), l);
        end
        drive(1'b1, 1'b1, 1'b1, 4'd14, PB'(0));
        check("midramp_reset_out", 0, int'(out_ay), 0);
        check("midramp_reset_holding", 0, int'(hold_ay), 1);
        check("midramp_reset_ym_out", 0, int'(out_ym), 0);
        drive(1'b0, 1'b0, 1'b1, 4'd14, PB'(0));
        check("midramp_release_out", 0, int'(out_ay), 0);
        check("midramp_release_holding", 0, int'(hold_ay), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
